// File: rtl/uart_tx_pkg.sv
// Shared constants and types for the bus-attached UART transmitter.
// Register offsets, CTRL/STATUS bit positions, FSM state encoding and the parity helper.
package uart_tx_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_TXDATA = 2'd2;
    localparam logic [1:0] REG_BAUD   = 2'd3;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_IE  = 1;
    localparam int CTRL_ODD = 2;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    // Even parity is the XOR of the data bits; odd parity inverts it.
    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO for the UART transmitter; head is presented combinationally on rdata.
// A push while full is accepted only if a pop happens on the same edge.
module uart_tx_fifo #(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == {CW{1'b0}});
    assign count     = r_count;
    assign rdata     = r_mem[r_rptr];
    assign w_pop_ok  = pop & ~empty;
    assign w_push_ok = push & (~full | w_pop_ok);

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= {AW{1'b0}};
            r_rptr  <= {AW{1'b0}};
            r_count <= {CW{1'b0}};
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + AW'(1'b1);
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + AW'(1'b1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1'b1);
                2'b01:   r_count <= r_count - CW'(1'b1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register file, TX FIFO, baud-timed serialiser.
// Define UART_TX_PARITY_EN to add a parity bit (CTRL[2] selects odd parity).
module bus_uart_tx
    import uart_tx_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int DEFAULT_DIV = 867
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic        busWe,
    input  logic [31:0] busAddr,
    input  logic [31:0] busWData,
    output logic [31:0] busRData,
    output logic        tx,
    output logic        txIrq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          r_en;
    logic          r_ie;
    logic [15:0]   r_baud;
    logic          r_ovf;
    tx_state_e     r_state;
    logic [15:0]   r_div_latch;
    logic [15:0]   r_div_cnt;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_tx;

    logic [1:0]    w_addr;
    logic          w_wr;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [31:0]   w_count32;
    logic [3:0]    w_cnt4;
    logic [7:0]    w_head;
    logic          w_busy;
    logic          w_bit_end;
    logic          w_odd;
    logic          w_ovf_set;
    logic          w_ovf_clr;
    logic [31:0]   w_rdata;
    logic          w_unused_ok;

`ifdef UART_TX_PARITY_EN
    logic          r_odd;
    logic          r_par;
    assign w_odd = r_odd;
`else
    assign w_odd = 1'b0;
`endif

    assign w_addr      = busAddr[3:2];
    assign w_wr        = sel & busWe;
    assign w_push      = w_wr & (w_addr == REG_TXDATA);
    assign w_busy      = (r_state != IDLE);
    assign w_bit_end   = (r_div_cnt == r_div_latch);
    assign w_pop       = r_en & ~w_empty &
                         ((r_state == IDLE) | ((r_state == STOP) & w_bit_end));
    assign w_ovf_set   = w_push & w_full & ~w_pop;
    assign w_ovf_clr   = w_wr & (w_addr == REG_STATUS) & busWData[ST_OVF];
    assign w_count32   = 32'(w_count);
    assign w_cnt4      = (w_count32 > 32'd15) ? 4'hF : w_count32[3:0];
    assign w_unused_ok = ^{busAddr[31:4], busAddr[1:0], busWData[31:16]};

    assign tx       = r_tx;
    assign txIrq    = r_ie & w_empty & ~w_busy;
    assign busRData = w_rdata;

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (busWData[7:0]),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    // CTRL, BAUD and the sticky overflow flag; a same-edge overflow beats a W1C clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_en   <= 1'b0;
            r_ie   <= 1'b0;
            r_baud <= 16'(DEFAULT_DIV);
            r_ovf  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_odd  <= 1'b0;
`endif
        end else begin
            if (w_wr && (w_addr == REG_CTRL)) begin
                r_en  <= busWData[CTRL_EN];
                r_ie  <= busWData[CTRL_IE];
`ifdef UART_TX_PARITY_EN
                r_odd <= busWData[CTRL_ODD];
`endif
            end
            if (w_wr && (w_addr == REG_BAUD)) begin
                r_baud <= busWData[15:0];
            end
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Serialiser: every bit state lasts div_latch+1 cycles, frames chain without a gap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_div_latch <= 16'd0;
            r_div_cnt   <= 16'd0;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 8'd0;
            r_tx        <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_par       <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_shift     <= w_head;
                        r_div_latch <= r_baud;
                        r_div_cnt   <= 16'd0;
`ifdef UART_TX_PARITY_EN
                        r_par       <= parity_bit(w_head, w_odd);
`endif
                        r_state     <= START;
                        r_tx        <= 1'b0;
                    end else begin
                        r_tx <= 1'b1;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_div_cnt <= 16'd0;
                        r_bit_cnt <= 3'd0;
                        r_state   <= DATA;
                        r_tx      <= r_shift[0];
                    end else begin
                        r_div_cnt <= r_div_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_div_cnt <= 16'd0;
                        if (r_bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= PARITY;
                            r_tx    <= r_par;
`else
                            r_state <= STOP;
                            r_tx    <= 1'b1;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + 16'd1;
                    end
                end
                PARITY: begin
                    if (w_bit_end) begin
                        r_div_cnt <= 16'd0;
                        r_state   <= STOP;
                        r_tx      <= 1'b1;
                    end else begin
                        r_div_cnt <= r_div_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        r_div_cnt <= 16'd0;
                        if (w_pop) begin
                            r_shift     <= w_head;
                            r_div_latch <= r_baud;
`ifdef UART_TX_PARITY_EN
                            r_par       <= parity_bit(w_head, w_odd);
`endif
                            r_state     <= START;
                            r_tx        <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                            r_tx    <= 1'b1;
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    // Combinational read mux; unselected or write-only locations read zero.
    always_comb begin
        w_rdata = 32'd0;
        if (sel) begin
            case (w_addr)
                REG_CTRL:   w_rdata = {29'd0, w_odd, r_ie, r_en};
                REG_STATUS: w_rdata = {24'd0, w_cnt4, r_ovf, w_busy, w_empty, w_full};
                REG_TXDATA: w_rdata = 32'd0;
                REG_BAUD:   w_rdata = {16'd0, r_baud};
                default:    w_rdata = 32'd0;
            endcase
        end else begin
            w_rdata = 32'd0;
        end
    end

endmodule

// File: tb/tb_bus_uart_tx.sv
// Scoreboard bench for bus_uart_tx: stimulus queues expected frames, a monitor checks tx cycle by cycle.
module tb_bus_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef struct {
        logic [7:0] data;
        int         div;
        bit         b2b;
        bit         par;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        sel;
    logic        busWe;
    logic [31:0] busAddr;
    logic [31:0] busWData;
    logic [31:0] busRData;
    logic        tx;
    logic        txIrq;

    int   n_tests;
    int   n_fail;
    bit   mon_en;
    exp_t exp_q[$];

    bus_uart_tx #(.FIFO_DEPTH(8), .DEFAULT_DIV(867)) dut (
        .clk      (clk),
        .reset    (reset),
        .sel      (sel),
        .busWe    (busWe),
        .busAddr  (busAddr),
        .busWData (busWData),
        .busRData (busRData),
        .tx       (tx),
        .txIrq    (txIrq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        sel = 1'b1; busWe = 1'b1; busAddr = a; busWData = d;
        @(posedge clk);
        #1;
        sel = 1'b0; busWe = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        sel = 1'b1; busWe = 1'b0; busAddr = a;
        #1;
        d = busRData;
        sel = 1'b0;
    endtask

    task automatic expect_frame(input logic [7:0] data, input int div, input bit b2b, input bit par);
        exp_t e;
        e.data = data; e.div = div; e.b2b = b2b; e.par = par;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        logic [31:0] d;
        int n;
        n = 0;
        do begin
            @(negedge clk);
            bus_read(32'h4, d);
            n++;
        end while (!(d[2] == 1'b0 && d[1] == 1'b1) && n < 5000);
        check(name, 32'(n >= 5000), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: on each start bit pop the next expected frame and check every bit-time.
    initial begin
        exp_t        e;
        logic [10:0] frame;
        int          nbits;
        int          idle_cnt;
        int          fcount;
        logic        got;
        idle_cnt = 100;
        fcount   = 0;
        forever begin
            @(negedge clk);
            if (mon_en && tx === 1'b0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 32'd1, 32'd0);
                    for (int k = 0; k < 200 && tx === 1'b0; k++) @(negedge clk);
                end else begin
                    e = exp_q.pop_front();
                    if (e.b2b) check($sformatf("frame%0d_gap", fcount), 32'(idle_cnt), 32'd0);
                    frame = {2'b11, e.data, 1'b0};
                    nbits = 10;
                    if (PAR_EN) begin
                        frame = {1'b1, e.par, e.data, 1'b0};
                        nbits = 11;
                    end
                    for (int b = 0; b < nbits; b++) begin
                        got = frame[b];
                        for (int c = 0; c <= e.div; c++) begin
                            if (b != 0 || c != 0) @(negedge clk);
                            if (tx !== frame[b]) got = tx;
                        end
                        check($sformatf("frame%0d_bit%0d", fcount, b), {31'd0, got}, {31'd0, frame[b]});
                    end
                    fcount++;
                end
                idle_cnt = 0;
            end else begin
                idle_cnt++;
            end
        end
    end

    initial begin
        logic [31:0] d;
        int          cnt;
        bit          seen;
        n_tests = 0; n_fail = 0; mon_en = 1'b0;
        reset = 1'b0; sel = 1'b0; busWe = 1'b0; busAddr = 32'd0; busWData = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_irq", {31'd0, txIrq}, 32'd0);
        bus_read(32'h0, d); check("rst_ctrl", d, 32'h0);
        bus_read(32'h4, d); check("rst_status", d, 32'h2);
        bus_read(32'hC, d); check("rst_baud", d, 32'd867);
        mon_en = 1'b1;

        // Test 1: 0x55 at BAUD=3, busy lasts 40 cycles from the first start cycle.
        bus_write(32'hC, 32'hFFFF_0003);
        bus_read(32'hC, d); check("baud_upper_zero", d, 32'h3);
        bus_write(32'h0, 32'h1);
        expect_frame(8'h55, 3, 1'b0, 1'b0);
        bus_write(32'h8, 32'h55);
        cnt = 0; seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            bus_read(32'h4, d);
            if (i == 0) check("t1_latency_idle", {31'd0, tx}, 32'd1);
            if (d[2]) begin
                if (!seen) check("t1_first_start", {31'd0, tx}, 32'd0);
                seen = 1'b1;
                cnt++;
            end else if (seen) begin
                break;
            end
        end
        check("t1_busy_len", 32'(cnt), 32'd40);
        bus_read(32'h8, d); check("txdata_reads_zero", d, 32'h0);
        wait_idle("t1_idle");

        // Test 2: overflow with the transmitter disabled; 9th byte is dropped.
        bus_write(32'h0, 32'h0);
        for (int i = 1; i <= 9; i++) bus_write(32'h8, 32'(i));
        bus_read(32'h4, d); check("t2_status_ovf", d, 32'h89);
        bus_write(32'h4, 32'h8);
        bus_read(32'h4, d); check("t2_status_clr", d, 32'h81);
        for (int i = 1; i <= 8; i++) expect_frame(8'(i), 1, (i != 1), 1'b0);
        bus_write(32'hC, 32'h1);
        bus_write(32'h0, 32'h1);
        wait_idle("t2_idle");
        check("t2_drained", 32'(exp_q.size()), 32'd0);

        // Test 3: back-to-back bytes, count-1 push/pop, interrupt after final stop.
        bus_write(32'h0, 32'h3);
        @(negedge clk);
        check("t3_irq_idle", {31'd0, txIrq}, 32'd1);
        sel = 1'b0; busAddr = 32'h0; #1;
        check("t3_unselected_read", busRData, 32'h0);
        expect_frame(8'hA0, 1, 1'b0, 1'b0);
        expect_frame(8'hA1, 1, 1'b1, 1'b0);
        bus_write(32'h8, 32'hA0);
        bus_write(32'h8, 32'hA1);
        @(negedge clk);
        check("t3_irq_busy", {31'd0, txIrq}, 32'd0);
        bus_read(32'h4, d); check("t3_status_cnt1", d, 32'h14);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
            if (cnt == 20) begin
                bus_read(32'h4, d); check("t3_status_empty", d, 32'h06);
            end
        end while (txIrq !== 1'b1 && cnt < 500);
        check("t3_irq_rise", 32'(cnt), 32'd40);
        bus_read(32'h4, d); check("t3_status_end", d, 32'h2);

        // Test 4: BAUD rewritten during DATA bit 3 only affects the next frame.
        bus_write(32'h0, 32'h1);
        expect_frame(8'h3C, 1, 1'b0, 1'b0);
        bus_write(32'h8, 32'h3C);
        repeat (9) @(posedge clk);
        #1;
        bus_write(32'hC, 32'h7);
        expect_frame(8'hC3, 7, 1'b1, 1'b0);
        bus_write(32'h8, 32'hC3);
        wait_idle("t4_idle");

        // Test 5: reset mid-frame forces tx high asynchronously and flushes state.
        mon_en = 1'b0;
        bus_write(32'hC, 32'h1);
        bus_write(32'h8, 32'h00);
        bus_write(32'h8, 32'h00);
        repeat (5) @(negedge clk);
        check("t5_tx_low", {31'd0, tx}, 32'd0);
        #2;
        reset = 1'b0;
        #1;
        check("t5_tx_async", {31'd0, tx}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        bus_read(32'h4, d); check("t5_status", d, 32'h2);
        bus_read(32'h0, d); check("t5_ctrl", d, 32'h0);
        bus_read(32'hC, d); check("t5_baud", d, 32'd867);
        repeat (10) @(negedge clk);
        check("t5_tx_idle", {31'd0, tx}, 32'd1);
        mon_en = 1'b1;

        // Test 6: parity selection (CTRL[2] is inert without the parity build).
        bus_write(32'hC, 32'h1);
        bus_write(32'h0, 32'h5);
        bus_read(32'h0, d); check("t6_ctrl_rb", d, PAR_EN ? 32'h5 : 32'h1);
        expect_frame(8'h07, 1, 1'b0, 1'b0);
        bus_write(32'h8, 32'h07);
        wait_idle("t6_odd_idle");
        bus_write(32'h0, 32'h1);
        expect_frame(8'h07, 1, 1'b0, 1'b1);
        bus_write(32'h8, 32'h07);
        wait_idle("t6_even_idle");

        check("final_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
